// File: rtl/multicycle_alu.sv
// Registered EXE-stage ALU: single-cycle ops finish in one cycle, unsigned MUL/DIV
// iterate one bit per cycle, with busy driving the pipeline stall.
module multicycle_alu #(
    parameter int unsigned WORD_LEN    = 32,
    parameter int unsigned EXE_CMD_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXE_CMD_LEN-1:0] exe_cmd,
    input  logic [WORD_LEN-1:0]    val1,
    input  logic [WORD_LEN-1:0]    val2,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LEN-1:0]    alu_out,
    output logic [WORD_LEN-1:0]    high
);
    localparam int unsigned ShW = $clog2(WORD_LEN);

    localparam logic [EXE_CMD_LEN-1:0] CmdAdd = EXE_CMD_LEN'(0);
    localparam logic [EXE_CMD_LEN-1:0] CmdSub = EXE_CMD_LEN'(1);
    localparam logic [EXE_CMD_LEN-1:0] CmdAnd = EXE_CMD_LEN'(2);
    localparam logic [EXE_CMD_LEN-1:0] CmdOr  = EXE_CMD_LEN'(3);
    localparam logic [EXE_CMD_LEN-1:0] CmdNor = EXE_CMD_LEN'(4);
    localparam logic [EXE_CMD_LEN-1:0] CmdXor = EXE_CMD_LEN'(5);
    localparam logic [EXE_CMD_LEN-1:0] CmdSll = EXE_CMD_LEN'(6);
    localparam logic [EXE_CMD_LEN-1:0] CmdSrl = EXE_CMD_LEN'(7);
    localparam logic [EXE_CMD_LEN-1:0] CmdSra = EXE_CMD_LEN'(8);
    localparam logic [EXE_CMD_LEN-1:0] CmdMul = EXE_CMD_LEN'(9);
    localparam logic [EXE_CMD_LEN-1:0] CmdDiv = EXE_CMD_LEN'(10);

    localparam logic [ShW-1:0] CntInit = ShW'(WORD_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                 state_q, state_d;
    logic [EXE_CMD_LEN-1:0] cmd_q, cmd_d;
    logic [WORD_LEN-1:0]    op_q, op_d;     // multiplicand for MUL, divisor for DIV
    logic [WORD_LEN-1:0]    acc_q, acc_d;   // product high half / partial remainder
    logic [WORD_LEN-1:0]    lo_q, lo_d;     // multiplier bits / dividend-quotient bits
    logic [ShW-1:0]         cnt_q, cnt_d;
    logic [WORD_LEN-1:0]    alu_out_q, alu_out_d;
    logic [WORD_LEN-1:0]    high_q, high_d;

    logic [ShW-1:0]      shamt;
    logic [WORD_LEN-1:0] single_res;
    logic [WORD_LEN:0]   mul_sum;
    logic [WORD_LEN-1:0] mul_acc, mul_lo;
    logic [WORD_LEN:0]   div_shift, div_diff;
    logic [WORD_LEN-1:0] div_acc, div_lo;
    logic [WORD_LEN-1:0] step_acc, step_lo;

    assign shamt = val2[ShW-1:0];

    always_comb begin
        single_res = '0;
        case (exe_cmd)
            CmdAdd:  single_res = val1 + val2;
            CmdSub:  single_res = val1 - val2;
            CmdAnd:  single_res = val1 & val2;
            CmdOr:   single_res = val1 | val2;
            CmdNor:  single_res = ~(val1 | val2);
            CmdXor:  single_res = val1 ^ val2;
            CmdSll:  single_res = val1 << shamt;
            CmdSrl:  single_res = val1 >> shamt;
            CmdSra:  single_res = $unsigned($signed(val1) >>> shamt);
            default: single_res = '0;
        endcase
    end

    // One iteration of shift-add multiply and restoring divide; the two share acc/lo.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, op_q} : '0);
        mul_acc   = mul_sum[WORD_LEN:1];
        mul_lo    = {mul_sum[0], lo_q[WORD_LEN-1:1]};
        div_shift = {acc_q, lo_q[WORD_LEN-1]};
        div_diff  = div_shift - {1'b0, op_q};
        if (!div_diff[WORD_LEN]) begin
            div_acc = div_diff[WORD_LEN-1:0];
            div_lo  = {lo_q[WORD_LEN-2:0], 1'b1};
        end else begin
            div_acc = div_shift[WORD_LEN-1:0];
            div_lo  = {lo_q[WORD_LEN-2:0], 1'b0};
        end
        step_acc = (cmd_q == CmdDiv) ? div_acc : mul_acc;
        step_lo  = (cmd_q == CmdDiv) ? div_lo : mul_lo;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        op_d      = op_q;
        acc_d     = acc_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        alu_out_d = alu_out_q;
        high_d    = high_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    cmd_d = exe_cmd;
                    op_d  = val2;
                    if ((exe_cmd == CmdMul) || (exe_cmd == CmdDiv)) begin
                        state_d = StRun;
                        cnt_d   = CntInit;
                        acc_d   = '0;
                        lo_d    = val1;
                    end else begin
                        state_d   = StDone;
                        alu_out_d = single_res;
                        high_d    = '0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                if (cnt_q == '0) begin
                    state_d   = StDone;
                    alu_out_d = step_lo;
                    high_d    = step_acc;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cmd_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            alu_out_q <= '0;
            high_q    <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            alu_out_q <= alu_out_d;
            high_q    <= high_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign alu_out = alu_out_q;
    assign high    = high_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_multicycle_alu;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    exe_cmd;
    logic [W-1:0]  val1;
    logic [W-1:0]  val2;
    logic          busy;
    logic          done;
    logic [W-1:0]  alu_out;
    logic [W-1:0]  high;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_alu #(
        .WORD_LEN   (W),
        .EXE_CMD_LEN(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .exe_cmd(exe_cmd),
        .val1   (val1),
        .val2   (val2),
        .busy   (busy),
        .done   (done),
        .alu_out(alu_out),
        .high   (high)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {high, alu_out} as the operation's mathematical definition gives it.
    function automatic logic [63:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b % 32;
        r  = '0;
        case (cmd)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = ~(a | b);
            4'd5:  r = a ^ b;
            4'd6:  r = a << sh;
            4'd7:  r = a >> sh;
            4'd8:  r = 32'($signed(a) >>> sh);
            4'd9:  return 64'(a) * 64'(b);
            4'd10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: r = '0;
        endcase
        return {32'h0, r};
    endfunction

    // Issues one op at the current negedge and returns in its DONE cycle (or on timeout).
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] exp;
        bit          iter;
        int          cyc;
        int          busy_cyc;
        exp   = model(cmd, a, b);
        iter  = (cmd == 4'd9) || (cmd == 4'd10);
        start = 1'b1; exe_cmd = cmd; val1 = a; val2 = b;
        @(negedge clk);
        start = 1'b0; exe_cmd = 4'($urandom); val1 = $urandom; val2 = $urandom;
        cyc = 1; busy_cyc = 0;
        while (!done && cyc < int'(W) + 8) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_latency"}, 64'(cyc), iter ? 64'(W + 1) : 64'd1);
        check_eq({tag, "_busy_cycles"}, 64'(busy_cyc), iter ? 64'(W) : 64'd0);
        check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check_eq({tag, "_result"}, {high, alu_out}, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] got;
        int          cyc;
        int          n_done;
        int          done_cyc;
        logic [3:0]  cmds  [4];
        logic [31:0] as    [4];
        logic [31:0] bs    [4];

        rst = 1'b1; start = 1'b0; exe_cmd = '0; val1 = '0; val2 = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_out", {high, alu_out}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd0, 32'hFFFF_FFFF, 32'h1, "add_wrap");
        run_op(4'd8, 32'h8000_0000, 32'h24, "sra");
        check_eq("sra_value", 64'(alu_out), 64'hF800_0000);
        run_op(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        @(negedge clk);
        check_eq("done_single_pulse", 64'(done), 64'd0);
        check_eq("out_held_in_idle", {high, alu_out}, 64'hFFFF_FFFE_0000_0001);
        run_op(4'd10, 32'd100, 32'd7, "div_100_7");
        run_op(4'd10, 32'd5, 32'd0, "div_by_zero");

        // start during RUN must be ignored and operand changes must not leak in
        start = 1'b1; exe_cmd = 4'd9; val1 = 32'hFFFF_FFFF; val2 = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        start = 1'b1; exe_cmd = 4'd0; val1 = 32'd7; val2 = 32'd9;
        @(negedge clk); cyc++;
        start = 1'b0; val1 = $urandom; val2 = $urandom;
        n_done = 0; done_cyc = 0; got = '0;
        while (cyc < int'(W) + 10) begin
            if (done) begin
                n_done++;
                done_cyc = cyc;
                got = {high, alu_out};
            end
            if (done && busy) check_eq("done_with_busy", 64'd1, 64'd0);
            @(negedge clk);
            cyc++;
        end
        check_eq("midrun_done_count", 64'(n_done), 64'd1);
        check_eq("midrun_done_cycle", 64'(done_cyc), 64'(W + 1));
        check_eq("midrun_result", got, 64'hFFFF_FFFE_0000_0001);

        // reset mid-DIV aborts with no done pulse
        start = 1'b1; exe_cmd = 4'd10; val1 = 32'd1000; val2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_out", {high, alu_out}, 64'd0);
        n_done = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_eq("abort_no_done", 64'(n_done), 64'd0);
        run_op(4'd1, 32'd3, 32'd5, "sub_after_abort");
        check_eq("sub_value", 64'(alu_out), 64'hFFFF_FFFE);

        // rst wins over a simultaneous start
        rst = 1'b1; start = 1'b1; exe_cmd = 4'd0; val1 = 32'd1; val2 = 32'd2;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_eq("rst_priority_done", 64'(done), 64'd0);
        check_eq("rst_priority_out", 64'(alu_out), 64'd0);
        @(negedge clk);

        // back-to-back single-cycle stream with start held high
        cmds[0] = 4'd0;  as[0] = 32'h1234_5678; bs[0] = 32'h1111_1111;
        cmds[1] = 4'd5;  as[1] = 32'hF0F0_F0F0; bs[1] = 32'hFF00_FF00;
        cmds[2] = 4'd6;  as[2] = 32'h0000_0003; bs[2] = 32'hFFFF_FFE4;
        cmds[3] = 4'd15; as[3] = 32'hDEAD_BEEF; bs[3] = 32'h1;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; exe_cmd = cmds[i]; val1 = as[i]; val2 = bs[i];
            @(negedge clk);
            check_eq("stream_done", 64'(done), 64'd1);
            check_eq("stream_result", {high, alu_out}, model(cmds[i], as[i], bs[i]));
        end
        start = 1'b0;
        @(negedge clk);
        check_eq("stream_idle", 64'(done), 64'd0);

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            c = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(9, 10)) : 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 20);
                1:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op(c, a, b, "rand");
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_eq("rand_pulse_end", 64'(done), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, registered successor to the execute-stage combinational ALU. Single-cycle ops (add/sub/logic/shift) return a registered result one cycle after `start`. Full-width unsigned multiply (2W-bit product) and unsigned divide (quotient + remainder) run iteratively over WORD_LEN cycles. Sits in the EXE stage; `busy` drives the hazard unit's pipeline stall.

## Interface
- `WORD_LEN`, 32: operand/result width; even, ≥4.
- `EXE_CMD_LEN`, 4: command field width.
- `clk  in  1`: clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: request; sampled only in IDLE or DONE.
- `exe_cmd  in  EXE_CMD_LEN`: operation, captured with `start`.
- `val1  in  WORD_LEN`: operand A, captured with `start`.
- `val2  in  WORD_LEN`: operand B, captured with `start`.
- `busy  out  1`: high while an iterative op is in progress.
- `done  out  1`: one-cycle pulse; `alu_out`/`high` valid.
- `alu_out  out  WORD_LEN`: result / product low word / quotient.
- `high  out  WORD_LEN`: product high word / remainder; 0 for single-cycle ops.

## Operation
- Commands: ADD=0, SUB=1, AND=2, OR=3, NOR=4, XOR=5, SLL=6, SRL=7, SRA=8, MUL=9, DIV=10. Undefined codes behave single-cycle, result 0, high 0.
- Arithmetic is modulo 2^WORD_LEN; no overflow flag. Shift amount = `val2[log2(WORD_LEN)-1:0]`, upper bits ignored. SRA replicates `val1` MSB.
- MUL: unsigned shift-add, one partial product per cycle; `{high, alu_out}` = val1*val2 exactly (2W bits).
- DIV: unsigned restoring, one quotient bit per cycle, MSB first. `alu_out` = quotient, `high` = remainder.
- Divide by zero: not special-cased in the datapath; result is quotient = all ones, remainder = val1, same latency.
- FSM: IDLE, RUN, DONE.
  - IDLE/DONE + `start` + single-cycle cmd → DONE (result registered).
  - IDLE/DONE + `start` + MUL/DIV → RUN, iteration counter loaded with WORD_LEN-1.
  - RUN: one iteration per cycle; counter==0 → DONE, else decrement.
  - DONE without `start` → IDLE.
- `start` while in RUN is ignored (no queueing); the upstream stall holds the request.
- `alu_out`/`high` hold their last values until the next DONE; they are not cleared in IDLE.
- Operand and cmd registers are loaded only on accepted `start`; input changes during RUN have no effect.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `alu_out`=0, `high`=0, counter and internal accumulators 0. A reset during RUN aborts the op; no `done` pulse.
- Single-cycle latency: `start` at cycle N → `done`=1 at N+1.
- MUL/DIV latency: `start` at N → `busy`=1 for cycles N+1..N+WORD_LEN, `done`=1 (`busy`=0) at N+WORD_LEN+1.
- Back-to-back: `start` asserted in the DONE cycle is accepted; single-cycle ops sustain one result per cycle.
- `done` is never asserted for more than one cycle per accepted op, and never concurrently with `busy`.
- `rst` has priority over `start` when both are high in the same cycle.

## Test plan
- Reset, then ADD 0xFFFFFFFF + 0x00000001 → `done` next cycle, `alu_out`=0, `high`=0; SRA 0x80000000 by 0x24 (amount 4) → 0xF8000000.
- MUL 0xFFFFFFFF × 0xFFFFFFFF → `busy` 32 cycles, `done` at start+33, `high`=0xFFFFFFFE, `alu_out`=0x00000001.
- DIV 100 / 7 → quotient 14, remainder 2 at start+33; DIV 5 / 0 → `alu_out`=0xFFFFFFFF, `high`=5.
- Issue MUL, pulse `start`=1 with ADD at cycle N+5 and change val1/val2 mid-RUN → ignored; MUL result unchanged, exactly one `done`.
- Assert `rst` at cycle N+10 of a DIV → next cycle `busy`=0, outputs 0, no `done`; a fresh SUB 3−5 then returns 0xFFFFFFFE.
- Back-to-back single-cycle stream (ADD, XOR, SLL, code 15) with `start` held high → `done` each cycle, results in order, code 15 yields 0.
